// File: rtl/log_e_pkg.sv
// log_e_pkg: shared constants, state encoding and default widths for log_e
// No ports. Provides LN2 (Q0.32), the error value, default DATA_WIDTH/INT_BITS
// and the controller state enum.
package log_e_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_INT_BITS   = 16;
   localparam logic [31:0] LN2     = 32'hB172_17F8;
   localparam logic [31:0] ERR_VAL = 32'h8000_0000;
   typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;
endpackage

// File: rtl/log_e_msb_find.sv
// log_e_msb_find: combinational priority encoder returning the highest set bit
// Ports:
//   i_x    [W-1:0]          operand
//   o_idx  [$clog2(W)-1:0]  index of the most significant set bit (0 when i_x==0)
//   o_zero                  high when i_x is all zeros
module log_e_msb_find #(
   parameter  int W  = 32,
   localparam int IW = $clog2(W)
)(
   input  logic [W-1:0]  i_x,
   output logic [IW-1:0] o_idx,
   output logic          o_zero
);
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < W; i++)
         if (i_x[i]) o_idx = IW'(i);
   end
   assign o_zero = ~|i_x;
endmodule

// File: rtl/log_e.sv
// log_e: iterative fixed-point natural logarithm, y = ln(x) in Q(INT_BITS).FRAC_BITS
// Ports:
//   clk_i, rst_i       clock (rising edge), synchronous active-high reset
//   valid_i, ready_o   operand handshake; ready_o high only when idle
//   x_i                signed operand
//   valid_o, ready_i   result handshake; result held until ready_i
//   y_o                signed result, stable while valid_o
//   err_o              operand was <= 0 (y_o is then the most negative value)
//   log2_sel_i         only with LOG_E_LOG2_SEL_EN: 1 selects log2(x) instead of ln(x)
// Optional feature macro: LOG_E_LOG2_SEL_EN
module log_e
   import log_e_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int INT_BITS   = DEF_INT_BITS
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] x_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] y_o,
   output logic                  err_o
`ifdef LOG_E_LOG2_SEL_EN
   ,input logic                  log2_sel_i
`endif
);
   localparam int FB = DATA_WIDTH - INT_BITS;
   localparam int IW = $clog2(DATA_WIDTH);
   localparam int CW = $clog2(FB + 1);
   localparam int SW = 2 * FB + 2;
   localparam int PW = DATA_WIDTH + 33;
   localparam logic [DATA_WIDTH-1:0] ERR_Y = {ERR_VAL[31], {(DATA_WIDTH-1){1'b0}}};

   state_t                       r_state, w_next;
   logic [DATA_WIDTH-1:0]        r_x, r_y, w_ln, w_res;
   logic signed [DATA_WIDTH-1:0] r_acc;
   logic [FB:0]                  r_m, w_m0, w_m_nxt;
   logic [CW-1:0]                r_cnt;
   logic                         r_err, w_zero, w_nonpos;
   logic [IW-1:0]                w_p;
   int                           w_k;
   logic [SW-1:0]                w_sq;
   logic signed [PW-1:0]         w_prod;

   log_e_msb_find #(.W(DATA_WIDTH)) u_msb (.i_x(r_x), .o_idx(w_p), .o_zero(w_zero));

   assign w_nonpos = r_x[DATA_WIDTH-1] | w_zero;
   assign w_k      = int'(w_p) - FB;
   // align the leading one to bit FB, giving m in [1,2) as unsigned Q1.FB
   assign w_m0     = (FB+1)'(w_k >= 0 ? r_x >> w_k : r_x << -w_k);
   // m*m lies in [1,4); its top bit says whether the square reached 2.0
   assign w_sq     = SW'(r_m) * SW'(r_m);
   assign w_m_nxt  = (FB+1)'(w_sq[SW-1] ? w_sq >> (FB+1) : w_sq >> FB);
   // two's-complement product is exact modulo 2^PW, so the signed acc times unsigned LN2 is correct
   assign w_prod   = PW'(r_acc) * PW'({1'b0, LN2});
   assign w_ln     = DATA_WIDTH'((w_prod + (PW'(1) << 31)) >>> 32);

`ifdef LOG_E_LOG2_SEL_EN
   logic r_sel;
   always_ff @(posedge clk_i)
      if (rst_i) r_sel <= 1'b0;
      else if (r_state == IDLE && valid_i) r_sel <= log2_sel_i;
   assign w_res = r_sel ? r_acc : w_ln;
`else
   assign w_res = w_ln;
`endif

   always_ff @(posedge clk_i) r_state <= rst_i ? IDLE : w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (valid_i) w_next = NORM;
         NORM:    w_next = w_nonpos ? DONE : ITER;
         ITER:    if (r_cnt == '0) w_next = SCALE;
         SCALE:   w_next = DONE;
         DONE:    if (ready_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_x   <= '0;
         r_y   <= '0;
         r_err <= 1'b0;
         r_acc <= '0;
         r_m   <= '0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: if (valid_i) r_x <= x_i;
            NORM: begin
               if (w_nonpos) begin
                  r_y   <= ERR_Y;
                  r_err <= 1'b1;
               end else begin
                  r_m   <= w_m0;
                  r_acc <= DATA_WIDTH'(w_k) <<< FB;
                  r_cnt <= CW'(FB - 1);
               end
            end
            ITER: begin
               r_m          <= w_m_nxt;
               r_acc[r_cnt] <= w_sq[SW-1];
               r_cnt        <= r_cnt - 1'b1;
            end
            SCALE: begin
               r_y   <= w_res;
               r_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign ready_o = r_state == IDLE;
   assign valid_o = r_state == DONE;
   assign y_o     = r_y;
   assign err_o   = r_err;
endmodule
